// File: rtl/slave_ram_initiator_pkg.sv
// slave_ram_pkg
//   Shared definitions for the slave-memory initiator: default widths and
//   timeouts, access-size encodings (bits per access) and the controller
//   state encoding.
package slave_ram_pkg;

    localparam int DEF_ADDR_W      = 10;
    localparam int DEF_DATA_W      = 64;
    localparam int DEF_SIZE_W      = 7;
    localparam int DEF_CYC_W       = 32;
    localparam int DEF_MEM_TIMEOUT = 64;
    localparam int DEF_RUN_TIMEOUT = 200000000;

    // Access size is expressed in bits on the slave port.
    localparam logic [DEF_SIZE_W-1:0] SZ8  = 7'd8;
    localparam logic [DEF_SIZE_W-1:0] SZ16 = 7'd16;
    localparam logic [DEF_SIZE_W-1:0] SZ32 = 7'd32;
    localparam logic [DEF_SIZE_W-1:0] SZ64 = 7'd64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MEM_REQ,
        ST_RSP,
        ST_START,
        ST_RUN,
        ST_FIN
    } state_t;

endpackage

// File: rtl/slave_ram_initiator_timeout_counter.sv
// timeout_counter
//   Saturating up-counter with a load-to-one and a limit flag. Used both to
//   bound the wait for a memory completion and to time accelerator runs.
// Ports
//   i_clk      clock, rising edge
//   i_rst_n    asynchronous active-low reset (count -> 0)
//   i_load     load count with 1 (first counted cycle)
//   i_en       increment by one, holding at all-ones
//   o_count    current count
//   o_at_limit count has reached LIMIT
module timeout_counter #(
    parameter int W     = 32,
    parameter int LIMIT = 64
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic         i_en,
    output logic [W-1:0] o_count,
    output logic         o_at_limit
);

    localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= W'(1);
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count    = r_count;
    assign o_at_limit = (r_count >= LIMIT_V);

endmodule

// File: rtl/slave_ram_initiator.sv
// slave_ram_initiator
//   Bus-master end of the accelerator slave-memory port plus start/done run
//   control. One command (read or write) or one run is in flight at a time.
//   Only channel 0 of the two-channel slave port is used; channel 1 is tied 0.
// Ports
//   clock, reset            clock / asynchronous active-low reset
//   cmd_*                   memory command in (valid/ready handshake)
//   rsp_*                   one-cycle completion pulse, read data, timeout error
//   run_req/busy/done       run control; run_cycles/run_timeout hold last run result
//   start_port, done_port   accelerator handshake
//   S_*, Sout_*             two-channel slave memory port to the accelerator
module slave_ram_initiator
    import slave_ram_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SIZE_W      = DEF_SIZE_W,
    parameter int CYC_W       = DEF_CYC_W,
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int RUN_TIMEOUT = DEF_RUN_TIMEOUT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [SIZE_W-1:0]     cmd_size,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    input  logic                  run_req,
    output logic                  run_busy,
    output logic                  run_done,
    output logic [CYC_W-1:0]      run_cycles,
    output logic                  run_timeout,
    output logic                  start_port,
    input  logic                  done_port,
    output logic [1:0]            S_oe_ram,
    output logic [1:0]            S_we_ram,
    output logic [2*ADDR_W-1:0]   S_addr_ram,
    output logic [2*DATA_W-1:0]   S_Wdata_ram,
    output logic [2*SIZE_W-1:0]   S_data_ram_size,
    input  logic [2*DATA_W-1:0]   Sout_Rdata_ram,
    input  logic [1:0]            Sout_DataRdy
);

    localparam int MEM_CNT_W = $clog2(MEM_TIMEOUT + 1);

    state_t              r_state;
    logic                r_cmd_ready;
    logic                r_oe;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [SIZE_W-1:0]   r_size;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_err;
    logic                r_start;
    logic                r_busy;
    logic                r_run_done;
    logic [CYC_W-1:0]    r_run_cycles;
    logic                r_run_timeout;

    logic                w_cmd_accept;
    logic                w_run_accept;
    logic                w_mem_at_limit;
    logic [MEM_CNT_W-1:0] w_unused_mem_count;
    logic                w_run_en;
    logic                w_run_at_limit;
    logic [CYC_W-1:0]    w_run_count;
    logic                w_unused_ch1;

    // A command takes priority; a run_req in the same cycle is dropped.
    assign w_cmd_accept = (r_state == ST_IDLE) && r_cmd_ready && cmd_valid;
    assign w_run_accept = (r_state == ST_IDLE) && r_cmd_ready && !cmd_valid && run_req;

    // Freeze the run counter on the cycle the run ends so the latched count
    // and the counter agree.
    assign w_run_en = ((r_state == ST_START) || (r_state == ST_RUN)) && !done_port && !w_run_at_limit;

    // Channel 1 is never used.
    assign w_unused_ch1 = ^{Sout_Rdata_ram[2*DATA_W-1:DATA_W], Sout_DataRdy[1]};

    timeout_counter #(
        .W     (MEM_CNT_W),
        .LIMIT (MEM_TIMEOUT)
    ) u_mem_wait (
        .i_clk      (clock),
        .i_rst_n    (reset),
        .i_load     (w_cmd_accept),
        .i_en       (r_state == ST_MEM_REQ),
        .o_count    (w_unused_mem_count),
        .o_at_limit (w_mem_at_limit)
    );

    timeout_counter #(
        .W     (CYC_W),
        .LIMIT (RUN_TIMEOUT)
    ) u_run_cnt (
        .i_clk      (clock),
        .i_rst_n    (reset),
        .i_load     (w_run_accept),
        .i_en       (w_run_en),
        .o_count    (w_run_count),
        .o_at_limit (w_run_at_limit)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_cmd_ready   <= 1'b0;
            r_oe          <= 1'b0;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_size        <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_start       <= 1'b0;
            r_busy        <= 1'b0;
            r_run_done    <= 1'b0;
            r_run_cycles  <= '0;
            r_run_timeout <= 1'b0;
        end else begin
            // Pulse outputs default low.
            r_rsp_valid <= 1'b0;
            r_start     <= 1'b0;
            r_run_done  <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (w_cmd_accept) begin
                        r_cmd_ready <= 1'b0;
                        r_oe        <= ~cmd_we;
                        r_we        <= cmd_we;
                        r_addr      <= cmd_addr;
                        r_wdata     <= cmd_wdata;
                        r_size      <= cmd_size;
                        r_state     <= ST_MEM_REQ;
                    end else if (w_run_accept) begin
                        r_cmd_ready   <= 1'b0;
                        r_start       <= 1'b1;
                        r_busy        <= 1'b1;
                        r_run_timeout <= 1'b0;
                        r_state       <= ST_START;
                    end
                end

                ST_MEM_REQ: begin
                    // Request stays stable until completion or timeout.
                    if (Sout_DataRdy[0] || w_mem_at_limit) begin
                        r_oe        <= 1'b0;
                        r_we        <= 1'b0;
                        r_addr      <= '0;
                        r_wdata     <= '0;
                        r_size      <= '0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RSP;
                        if (Sout_DataRdy[0]) begin
                            r_rsp_rdata <= r_we ? '0 : Sout_Rdata_ram[DATA_W-1:0];
                            r_rsp_err   <= 1'b0;
                        end else begin
                            r_rsp_rdata <= '0;
                            r_rsp_err   <= 1'b1;
                        end
                    end
                end

                ST_RSP: begin
                    r_cmd_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end

                ST_START, ST_RUN: begin
                    // done_port wins over a simultaneous timeout.
                    if (done_port) begin
                        r_run_cycles <= w_run_count;
                        r_busy       <= 1'b0;
                        r_run_done   <= 1'b1;
                        r_state      <= ST_FIN;
                    end else if (w_run_at_limit) begin
                        r_run_cycles  <= w_run_count;
                        r_run_timeout <= 1'b1;
                        r_busy        <= 1'b0;
                        r_run_done    <= 1'b1;
                        r_state       <= ST_FIN;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end

                ST_FIN: begin
                    r_cmd_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready       = r_cmd_ready;
    assign rsp_valid       = r_rsp_valid;
    assign rsp_rdata       = r_rsp_rdata;
    assign rsp_err         = r_rsp_err;
    assign run_busy        = r_busy;
    assign run_done        = r_run_done;
    assign run_cycles      = r_run_cycles;
    assign run_timeout     = r_run_timeout;
    assign start_port      = r_start;
    assign S_oe_ram        = {1'b0, r_oe};
    assign S_we_ram        = {1'b0, r_we};
    assign S_addr_ram      = {{ADDR_W{1'b0}}, r_addr};
    assign S_Wdata_ram     = {{DATA_W{1'b0}}, r_wdata};
    assign S_data_ram_size = {{SIZE_W{1'b0}}, r_size};

endmodule

// File: tb/tb_slave_ram_initiator.sv
module tb_slave_ram_initiator;
    import slave_ram_pkg::*;

    logic          clock;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [9:0]    cmd_addr;
    logic [63:0]   cmd_wdata;
    logic [6:0]    cmd_size;
    logic          rsp_valid;
    logic [63:0]   rsp_rdata;
    logic          rsp_err;
    logic          run_req;
    logic          run_busy;
    logic          run_done;
    logic [31:0]   run_cycles;
    logic          run_timeout;
    logic          start_port;
    logic          done_port;
    logic [1:0]    S_oe_ram;
    logic [1:0]    S_we_ram;
    logic [19:0]   S_addr_ram;
    logic [127:0]  S_Wdata_ram;
    logic [13:0]   S_data_ram_size;
    logic [127:0]  Sout_Rdata_ram;
    logic [1:0]    Sout_DataRdy;

    slave_ram_initiator #(
        .ADDR_W(10), .DATA_W(64), .SIZE_W(7), .CYC_W(32),
        .MEM_TIMEOUT(8), .RUN_TIMEOUT(20)
    ) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_size(cmd_size),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .run_req(run_req), .run_busy(run_busy), .run_done(run_done),
        .run_cycles(run_cycles), .run_timeout(run_timeout),
        .start_port(start_port), .done_port(done_port),
        .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
        .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
        .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit          is_run;
        logic [63:0] rdata;
        logic        err;
        logic [31:0] cycles;
        logic        tmo;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp_v);
        end
    endtask

    task automatic push_mem(input logic [63:0] rdata, input logic err);
        sb.push_back('{is_run: 1'b0, rdata: rdata, err: err, cycles: 32'd0, tmo: 1'b0});
    endtask

    task automatic push_run(input logic [31:0] cycles, input logic tmo);
        sb.push_back('{is_run: 1'b1, rdata: 64'd0, err: 1'b0, cycles: cycles, tmo: tmo});
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic any_out();
        return |{cmd_ready, rsp_valid, rsp_rdata, rsp_err, run_busy, run_done, run_cycles,
                 run_timeout, start_port, S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram,
                 S_data_ram_size};
    endfunction

    // Monitor: every completion pulse is matched against the oldest expectation.
    always @(negedge clock) begin
        if (reset === 1'b1 && (rsp_valid === 1'b1 || run_done === 1'b1)) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: rsp_valid=%0b run_done=%0b with no expectation", rsp_valid, run_done);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_kind", 128'(run_done), 128'(mon_e.is_run));
                if (mon_e.is_run) begin
                    chk("sb_run_cycles", 128'(run_cycles), 128'(mon_e.cycles));
                    chk("sb_run_timeout", 128'(run_timeout), 128'(mon_e.tmo));
                    chk("sb_run_busy_low", 128'(run_busy), 128'(0));
                end else begin
                    chk("sb_rsp_rdata", 128'(rsp_rdata), 128'(mon_e.rdata));
                    chk("sb_rsp_err", 128'(rsp_err), 128'(mon_e.err));
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int n_oe;
        int n_start;
        logic seen_we;
        logic seen_ready;

        reset = 1'b0;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_size = '0;
        run_req = 1'b0; done_port = 1'b0; Sout_Rdata_ram = '0; Sout_DataRdy = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_outputs_zero", 128'(any_out()), 128'(0));
        chk("rst_cmd_ready", 128'(cmd_ready), 128'(0));
        reset = 1'b1;
        #1;
        chk("ready_before_edge", 128'(cmd_ready), 128'(0));
        tick();
        chk("ready_after_release", 128'(cmd_ready), 128'(1));

        // Write 0xDEADBEEF to 0x010, completion in the second request cycle
        push_mem(64'd0, 1'b0);
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 10'h010; cmd_wdata = 64'hDEAD_BEEF; cmd_size = SZ32;
        tick();
        cmd_valid = 1'b0;
        chk("wr_we_c1", 128'(S_we_ram), 128'(2'b01));
        chk("wr_oe_c1", 128'(S_oe_ram), 128'(2'b00));
        chk("wr_addr", 128'(S_addr_ram), 128'(20'h00010));
        chk("wr_wdata", S_Wdata_ram, 128'(64'hDEAD_BEEF));
        chk("wr_size", 128'(S_data_ram_size), 128'(14'd32));
        chk("wr_ready_busy", 128'(cmd_ready), 128'(0));
        tick();
        chk("wr_we_c2", 128'(S_we_ram), 128'(2'b01));
        Sout_DataRdy = 2'b01;
        tick();
        Sout_DataRdy = 2'b00;
        chk("wr_we_released", 128'(S_we_ram), 128'(0));
        chk("wr_rsp_valid", 128'(rsp_valid), 128'(1));
        tick();
        chk("wr_rsp_one_cycle", 128'(rsp_valid), 128'(0));
        chk("wr_ready_again", 128'(cmd_ready), 128'(1));

        // Read 0x010 with immediate completion; channel 1 carries junk
        push_mem(64'hDEAD_BEEF, 1'b0);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 10'h010; cmd_wdata = '0; cmd_size = SZ32;
        Sout_Rdata_ram = {64'hFFFF_FFFF_FFFF_FFFF, 64'hDEAD_BEEF};
        Sout_DataRdy = 2'b11;
        tick();
        cmd_valid = 1'b0;
        chk("rd_oe_c1", 128'(S_oe_ram), 128'(2'b01));
        chk("rd_we_c1", 128'(S_we_ram), 128'(0));
        tick();
        Sout_DataRdy = 2'b00;
        Sout_Rdata_ram = '0;
        chk("rd_oe_released", 128'(S_oe_ram), 128'(0));
        chk("rd_rsp_valid", 128'(rsp_valid), 128'(1));
        tick();

        // Read that never completes: timeout after 8 request cycles
        push_mem(64'd0, 1'b1);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 10'h020;
        tick();
        cmd_valid = 1'b0;
        n = 0; n_oe = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            if (S_oe_ram == 2'b01) n_oe++;
            tick();
            n++;
        end
        chk("to_oe_cycles", 128'(n_oe), 128'(8));
        chk("to_rsp_seen", 128'(rsp_valid), 128'(1));
        chk("to_oe_low_after", 128'(S_oe_ram), 128'(0));
        tick();
        chk("to_err_held", 128'(rsp_err), 128'(1));
        chk("to_rdata_zero", 128'(rsp_rdata), 128'(0));

        // Run ended by done_port five cycles after start_port; commands blocked
        push_run(32'd6, 1'b0);
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 10'h0AA;
        chk("run_start_hi", 128'(start_port), 128'(1));
        chk("run_busy_hi", 128'(run_busy), 128'(1));
        n_start = 0; seen_we = 1'b0; seen_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (start_port) n_start++;
            if (S_we_ram != 2'b00) seen_we = 1'b1;
            if (cmd_ready) seen_ready = 1'b1;
            if (i == 5) done_port = 1'b1;
        end
        tick();
        done_port = 1'b0;
        chk("run_start_one_cycle", 128'(n_start), 128'(0));
        chk("run_cmd_not_issued", 128'(seen_we), 128'(0));
        chk("run_ready_low", 128'(seen_ready), 128'(0));
        chk("run_done_pulse", 128'(run_done), 128'(1));
        chk("run_cycles_6", 128'(run_cycles), 128'(6));
        chk("run_ready_in_fin", 128'(cmd_ready), 128'(0));
        cmd_valid = 1'b0;
        tick();
        chk("run_done_one_cycle", 128'(run_done), 128'(0));
        chk("run_no_mem_after", 128'(S_we_ram), 128'(0));

        // Run without done_port: abort at RUN_TIMEOUT=20
        push_run(32'd20, 1'b1);
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        n = 0;
        while (run_done !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        chk("tmo_done_seen", 128'(run_done), 128'(1));
        chk("tmo_flag", 128'(run_timeout), 128'(1));
        chk("tmo_cycles", 128'(run_cycles), 128'(20));
        tick();
        chk("tmo_flag_held", 128'(run_timeout), 128'(1));

        // done_port during START: count 1, timeout flag cleared
        push_run(32'd1, 1'b0);
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        done_port = 1'b1;
        chk("start_clears_tmo", 128'(run_timeout), 128'(0));
        tick();
        done_port = 1'b0;
        chk("short_run_done", 128'(run_done), 128'(1));
        chk("short_run_cycles", 128'(run_cycles), 128'(1));
        tick();

        // Reset in the middle of a memory request
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 10'h055; cmd_wdata = 64'h1234; cmd_size = SZ16;
        tick();
        cmd_valid = 1'b0;
        chk("abort_mem_we", 128'(S_we_ram), 128'(2'b01));
        reset = 1'b0;
        #1;
        chk("abort_mem_outs_zero", 128'(any_out()), 128'(0));
        tick();
        reset = 1'b1;
        tick();
        chk("abort_mem_ready", 128'(cmd_ready), 128'(1));

        // Reset in the middle of a run
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        tick();
        tick();
        chk("abort_run_busy", 128'(run_busy), 128'(1));
        reset = 1'b0;
        #1;
        chk("abort_run_outs_zero", 128'(any_out()), 128'(0));
        tick();
        reset = 1'b1;
        tick();
        chk("abort_run_ready", 128'(cmd_ready), 128'(1));

        // Normal write after the aborts
        push_mem(64'd0, 1'b0);
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 10'h3FF; cmd_wdata = 64'hCAFE_F00D_0123_4567; cmd_size = SZ64;
        Sout_DataRdy = 2'b01;
        tick();
        cmd_valid = 1'b0;
        chk("post_we", 128'(S_we_ram), 128'(2'b01));
        chk("post_addr", 128'(S_addr_ram), 128'(20'h003FF));
        chk("post_wdata", S_Wdata_ram, 128'(64'hCAFE_F00D_0123_4567));
        chk("post_size", 128'(S_data_ram_size), 128'(14'd64));
        tick();
        Sout_DataRdy = 2'b00;
        chk("post_rsp_valid", 128'(rsp_valid), 128'(1));
        tick();
        tick();

        chk("sb_empty", 128'(sb.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
